// File: rtl/serial_write_queue.sv
// Byte queue feeding the serial write buffer: parallel words are buffered in a
// small circular FIFO and issued one at a time with a start strobe / done handshake.
module serial_write_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_WIDTH-1:0]    push_data,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     busy,
  output logic                     buf_start,
  output logic [DATA_WIDTH-1:0]    buf_data,
  input  logic                     buf_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, GUARD, WAIT_DONE} state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q;
  state_e                state_q;
  logic                  busy_q, buf_start_q;
  logic [DATA_WIDTH-1:0] buf_data_q;
  logic                  push_ok, pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign buf_start = buf_start_q;
  assign buf_data = buf_data_q;

  // Fullness is judged on the registered count, so a same-cycle pop never rescues a push.
  assign push_ok = push && !full && !flush;
  assign pop     = (state_q == IDLE) && !empty && buf_done;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Flush drops everything still queued; a word popped this cycle is already in flight.
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= push && full;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; count and pointers gate every read.
  always_ff @(posedge sys_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      buf_start_q <= 1'b0;
      buf_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          buf_start_q <= 1'b0;
          busy_q      <= 1'b0;
          if (pop) begin
            buf_data_q  <= mem_q[rd_ptr_q];
            buf_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= START;
          end
        end
        START: begin
          buf_start_q <= 1'b0;
          state_q     <= GUARD;
        end
        // The buffer only drops done after it has seen start, so skip one sample.
        GUARD: state_q <= WAIT_DONE;
        WAIT_DONE: begin
          if (buf_done) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          buf_start_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_write_queue.sv
// Directed bench for serial_write_queue: a write-buffer model answers each start,
// and a monitor checks every issued word against a queue of expected words.
module tb_serial_write_queue;

  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          flush = 1'b0;
  logic          full, empty, overflow, busy, buf_start, buf_done;
  logic [2:0]    count;
  logic [DW-1:0] buf_data;

  logic hold_low = 1'b0;
  logic shift_busy = 1'b0;

  int total = 0;
  int bad = 0;
  int n_issued = 0;
  int ovf_pulses = 0;
  int max_count = 0;
  logic prev_start = 1'b0;
  logic [DW-1:0] exp_q[$];

  serial_write_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .rst(rst), .push(push), .push_data(push_data), .flush(flush),
    .full(full), .empty(empty), .count(count), .overflow(overflow), .busy(busy),
    .buf_start(buf_start), .buf_data(buf_data), .buf_done(buf_done)
  );

  always #5 sys_clk = ~sys_clk;

  assign buf_done = !shift_busy && !hold_low;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Write buffer model: done drops two cycles after start and stays low for 8 data clocks.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (buf_start === 1'b1) begin
        repeat (2) @(negedge sys_clk);
        shift_busy = 1'b1;
        repeat (8) @(negedge sys_clk);
        shift_busy = 1'b0;
      end
    end
  end

  // Monitor: compare every issued word against the scoreboard.
  always @(negedge sys_clk) begin
    if (!rst) begin
      if (buf_start === 1'b1) begin
        n_issued++;
        check("start_single_cycle", {31'd0, prev_start}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_start: buf_data=%0h with nothing expected", buf_data);
        end else begin
          check("issued_word", {24'd0, buf_data}, {24'd0, exp_q.pop_front()});
        end
      end
      if (overflow === 1'b1) ovf_pulses++;
      if (int'(count) > max_count) max_count = int'(count);
    end
    prev_start = buf_start;
  end

  // Called at a negedge: drives one push through the next edge and returns at the following negedge.
  task automatic push_word(input logic [DW-1:0] d, input bit accept);
    push = 1'b1;
    push_data = d;
    if (accept) exp_q.push_back(d);
    @(negedge sys_clk);
    push = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(busy === 1'b0 && empty === 1'b1 && buf_done === 1'b1) && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check(name, {31'd0, n < budget}, 32'd1);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;

    // Reset state
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_start", {31'd0, buf_start}, 32'd0);
    check("rst_data", {24'd0, buf_data}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);

    // 1: single word, latency and handshake
    push_word(8'h9C, 1'b1);
    check("t1_count_after_push", {29'd0, count}, 32'd1);
    @(negedge sys_clk);
    check("t1_start", {31'd0, buf_start}, 32'd1);
    check("t1_data", {24'd0, buf_data}, 32'h9C);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_count_after_pop", {29'd0, count}, 32'd0);
    @(negedge sys_clk);
    check("t1_start_low", {31'd0, buf_start}, 32'd0);
    repeat (4) @(negedge sys_clk);
    check("t1_busy_while_shift", {31'd0, busy}, 32'd1);
    check("t1_data_held", {24'd0, buf_data}, 32'h9C);
    wait_idle("t1_idle_timeout", 40);
    check("t1_empty", {31'd0, empty}, 32'd1);
    check("t1_count", {29'd0, count}, 32'd0);

    // 2: three back-to-back pushes
    max_count = 0;
    push_word(8'h9C, 1'b1);
    push_word(8'hE4, 1'b1);
    push_word(8'hB5, 1'b1);
    wait_idle("t2_idle_timeout", 100);
    check("t2_peak_count", max_count, 32'd2);
    check("t2_no_overflow", ovf_pulses, 32'd0);
    check("t2_scoreboard_empty", exp_q.size(), 32'd0);

    // 3: fill while the buffer is stalled, then overflow and drain
    push_word(8'h01, 1'b1);
    @(negedge sys_clk);
    check("t3_first_issued", {24'd0, buf_data}, 32'h01);
    hold_low = 1'b1;
    push_word(8'h02, 1'b1);
    push_word(8'h03, 1'b1);
    push_word(8'h04, 1'b1);
    push_word(8'h05, 1'b1);
    check("t3_full", {31'd0, full}, 32'd1);
    check("t3_count4", {29'd0, count}, 32'd4);
    push_word(8'h06, 1'b0);
    check("t3_overflow_pulse", {31'd0, overflow}, 32'd1);
    check("t3_count_kept", {29'd0, count}, 32'd4);
    @(negedge sys_clk);
    check("t3_overflow_single", {31'd0, overflow}, 32'd0);
    check("t3_overflow_count", ovf_pulses, 32'd1);
    hold_low = 1'b0;
    wait_idle("t3_idle_timeout", 200);
    check("t3_scoreboard_empty", exp_q.size(), 32'd0);

    // 4: reset while a word is queued
    push_word(8'h9C, 1'b1);
    push_word(8'hE4, 1'b1);
    check("t4_first_start", {31'd0, buf_start}, 32'd1);
    @(negedge sys_clk);
    check("t4_queued", {29'd0, count}, 32'd1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge sys_clk);
    rst = 1'b0;
    check("t4_rst_count", {29'd0, count}, 32'd0);
    check("t4_rst_empty", {31'd0, empty}, 32'd1);
    check("t4_rst_busy", {31'd0, busy}, 32'd0);
    check("t4_rst_start", {31'd0, buf_start}, 32'd0);
    check("t4_rst_data", {24'd0, buf_data}, 32'd0);
    base = n_issued;
    repeat (15) @(negedge sys_clk);
    check("t4_no_start_after_rst", n_issued - base, 32'd0);
    push_word(8'hB5, 1'b1);
    wait_idle("t4_idle_timeout", 60);
    check("t4_one_issued", n_issued - base, 32'd1);

    // 5: flush with a concurrent push during transmission
    base = n_issued;
    push_word(8'h11, 1'b1);
    push_word(8'h22, 1'b1);
    push_word(8'h33, 1'b1);
    check("t5_count_before_flush", {29'd0, count}, 32'd2);
    flush = 1'b1;
    push = 1'b1;
    push_data = 8'h44;
    @(negedge sys_clk);
    flush = 1'b0;
    push = 1'b0;
    exp_q.delete();
    check("t5_count_flushed", {29'd0, count}, 32'd0);
    check("t5_empty", {31'd0, empty}, 32'd1);
    check("t5_inflight_busy", {31'd0, busy}, 32'd1);
    check("t5_inflight_data", {24'd0, buf_data}, 32'h11);
    wait_idle("t5_idle_timeout", 60);
    repeat (5) @(negedge sys_clk);
    check("t5_only_one_issued", n_issued - base, 32'd1);

    // 6: push coinciding with a pop at three entries, pointers wrapping
    push_word(8'h5A, 1'b1);
    @(negedge sys_clk);
    check("t6_x_start", {31'd0, buf_start}, 32'd1);
    hold_low = 1'b1;
    push_word(8'hA1, 1'b1);
    push_word(8'hA2, 1'b1);
    push_word(8'hA3, 1'b1);
    repeat (12) @(negedge sys_clk);
    check("t6_count3", {29'd0, count}, 32'd3);
    hold_low = 1'b0;
    @(negedge sys_clk);
    check("t6_idle_before_pop", {31'd0, busy}, 32'd0);
    push_word(8'h7F, 1'b1);
    check("t6_count_unchanged", {29'd0, count}, 32'd3);
    check("t6_pop_start", {31'd0, buf_start}, 32'd1);
    wait_idle("t6_idle_timeout", 200);
    check("t6_scoreboard_empty", exp_q.size(), 32'd0);
    check("t6_last_word", {24'd0, buf_data}, 32'h7F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_write_queue.md
Name: serial_write_queue

Overview:
- Byte queue and sequencer directly upstream of the serial write buffer.
- Accepts parallel words from the control logic into a small FIFO, then hands them one at a time to the write buffer.
- Each handoff drives the buffer's data_in and pulses its start, then waits for its done_sig before sending the next word.
- Lets upstream logic queue a multi-byte response without tracking per-byte completion.

Parameters:
DATA_WIDTH, 8, width of each queued word; equals the write buffer's BUF_SIZE.
DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
sys_clk  input  1  system clock.
rst  input  1  synchronous active-high reset.
push  input  1  enqueue push_data this cycle.
push_data  input  DATA_WIDTH  word to enqueue.
flush  input  1  discard all queued, not-yet-issued words.
full  output  1  FIFO holds DEPTH words.
empty  output  1  FIFO holds 0 words.
count  output  clog2(DEPTH)+1  words currently in FIFO (excludes the word being transmitted).
overflow  output  1  one-cycle pulse when a push is rejected.
busy  output  1  a word is issued to the buffer and not yet done.
buf_start  output  1  start strobe to write buffer (one cycle).
buf_data  output  DATA_WIDTH  word presented to write buffer data_in; held stable from the start cycle until done.
buf_done  input  1  write buffer done_sig; high when the buffer is idle or finished, low while shifting.

Behaviour:
- Reset, sampled on the sys_clk rising edge:
  - FIFO pointers and count go to 0.
  - empty=1, full=0, overflow=0, busy=0, buf_start=0, buf_data=0.
  - State goes to IDLE.
- Reset mid-transmission abandons the current word; buf_start is never asserted in the reset cycle.
- FIFO storage:
  - Circular register array with read and write pointers of clog2(DEPTH) bits; pointers wrap modulo DEPTH.
  - count is tracked separately. full = (count==DEPTH), empty = (count==0).
- Push:
  - Accepted when push=1 and full=0. Data is written at the write pointer and the pointer increments.
  - Push while full is dropped, the FIFO is unchanged, and overflow=1 in the next cycle. This holds even if a pop occurs in the same cycle.
- Pop: performed only by the state machine in IDLE. The word at the read pointer is loaded into buf_data and the read pointer increments.
- Push and pop in the same cycle (not full): both performed; count unchanged.
- Push into an empty FIFO in the same cycle as a pop: no pop that cycle; the word is seen next cycle.
- Flush:
  - Read pointer := write pointer and count := 0, next cycle.
  - An in-flight word is not affected; busy and the state machine continue.
  - flush together with push: flush wins and the pushed word is discarded.
- State machine:
  - IDLE: busy=0. If empty=0 and buf_done=1: pop, go to START. Otherwise stay.
  - START: buf_start=1 for exactly this cycle, busy=1. Go to GUARD.
  - GUARD: one cycle, busy=1. Ignores buf_done while the buffer drops it after start. Go to WAIT_DONE.
  - WAIT_DONE: busy=1. When buf_done=1, go to IDLE.
- Latency:
  - Push at edge N into an empty queue with idle buffer: count=1 after edge N, pop at edge N+1, buf_start high during the cycle after edge N+1.
  - Back-to-back words: next buf_start occurs 2 cycles after buf_done is seen high in WAIT_DONE (WAIT_DONE→IDLE→START).
- buf_data changes only on a pop. It is held through START, GUARD and WAIT_DONE and retains its last value in IDLE.
- Words are issued strictly in push order, with no duplication or loss except via flush, overflow or rst.

Test Plan:
1. Reset, then push 0x9C once with buf_done held high, and lower it 2 cycles after buf_start for 8 data clocks → buf_start single-cycle pulse with buf_data=0x9C, busy high until buf_done returns, then empty=1 and count=0.
2. Push 0x9C, 0xE4, 0xB5 on consecutive cycles (DEPTH=4) → count peaks at 2, since the first word pops immediately; three buf_start pulses in order 0x9C, 0xE4, 0xB5, each only after the previous buf_done rising; no overflow.
3. Hold buf_done low and push 5 words 0x01..0x05 → the first word issues, full=1 after the 5th push; push of 0x06 gives overflow=1 for one cycle and count stays 4; releasing buf_done drains 0x02..0x05 in order.
4. Push 0x9C, 0xE4 and, while 0xE4 is queued, assert rst for one cycle → all outputs return to reset values, no further buf_start, and a subsequent push 0xB5 issues normally.
5. During transmission of 0x11 with 0x22, 0x33 queued, assert flush together with push of 0x44 → 0x11 completes; count=0, 0x44 discarded, no further buf_start.
6. With the FIFO at 3 entries and one pop occurring, push 0x7F in the same cycle → count stays 3, read/write pointers wrap correctly across DEPTH, and 0x7F is issued last.
